// File: rtl/edac_encode_4bit_seq.sv
// Sequential EDAC encoder: bit-serial CRC-4 long division followed by a Hamming(12,8)
// wrap of {data, crc}. The 16-bit codeword is laid out for the downstream 4-bit decoder.
module edac_encode_4bit_seq #(
  parameter int DIV_STEPS      = 4,
  parameter int INJ_EN_DEFAULT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_data,
  input  logic [3:0]  CRC_POLY,
  input  logic        inj_en,
  input  logic [3:0]  inj_pos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Dout,
  output logic        poly_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_HAM  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [1:0] LAST_K  = 2'(DIV_STEPS - 1);
  localparam logic       INJ_DEF = (INJ_EN_DEFAULT != 0);

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  t_q, t_d;
  logic [7:0]  p_q, p_d;
  logic [3:0]  data_q, data_d;
  logic [3:0]  poly_q, poly_d;
  logic        inj_en_q, inj_en_d;
  logic [3:0]  inj_pos_q, inj_pos_d;
  logic [15:0] dout_q, dout_d;
  logic        out_valid_q, out_valid_d;
  logic        poly_err_q, poly_err_d;

  // One long-division step: subtract (XOR) the aligned polynomial when the
  // current leading dividend bit is set.
  function automatic logic [7:0] div_step(input logic [7:0] t,
                                          input logic [7:0] p,
                                          input logic [1:0] k);
    logic [2:0] lead;
    lead = 3'd7 - {1'b0, k};
    div_step = t[lead] ? (t ^ p) : t;
  endfunction

  function automatic logic [15:0] hamming_encode(input logic [3:0] d,
                                                 input logic [3:0] crc);
    logic [15:0] c;
    c       = '0;
    c[2]    = crc[0];
    c[4]    = crc[1];
    c[5]    = crc[2];
    c[6]    = crc[3];
    c[8]    = d[0];
    c[9]    = d[1];
    c[10]   = d[2];
    c[11]   = d[3];
    c[0]    = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1]    = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3]    = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[7]    = c[8] ^ c[9] ^ c[10] ^ c[11];
    hamming_encode = c;
  endfunction

  // Flip happens after parity so the decoder sees a genuine single-bit error;
  // positions 12..15 are outside the code and leave the word untouched.
  function automatic logic [15:0] inject_fault(input logic [15:0] c,
                                               input logic        en,
                                               input logic [3:0]  pos);
    logic [15:0] r;
    r = c;
    if (en && (pos < 4'd12)) begin
      r[pos] = ~c[pos];
    end
    inject_fault = r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_DIV;
      S_DIV:  if (k_q == LAST_K) state_d = S_HAM;
      S_HAM:  state_d = S_OUT;
      S_OUT:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
  end

  always_comb begin
    k_d         = k_q;
    t_d         = t_q;
    p_d         = p_q;
    data_d      = data_q;
    poly_d      = poly_q;
    inj_en_d    = inj_en_q;
    inj_pos_d   = inj_pos_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    poly_err_d  = poly_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          poly_d    = CRC_POLY;
          inj_en_d  = inj_en | INJ_DEF;
          inj_pos_d = inj_pos;
          t_d       = {in_data, 4'b0000};
          p_d       = {CRC_POLY, 4'b0000};
          k_d       = 2'd0;
        end
      end
      S_DIV: begin
        t_d = div_step(t_q, p_q, k_q);
        p_d = p_q >> 1;
        k_d = k_q + 2'd1;
      end
      S_HAM: begin
        dout_d      = inject_fault(hamming_encode(data_q, t_q[3:0]), inj_en_q, inj_pos_q);
        out_valid_d = 1'b1;
        poly_err_d  = ~poly_q[3];
      end
      S_OUT: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q         <= '0;
      t_q         <= '0;
      p_q         <= '0;
      data_q      <= '0;
      poly_q      <= '0;
      inj_en_q    <= 1'b0;
      inj_pos_q   <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      poly_err_q  <= 1'b0;
    end else begin
      k_q         <= k_d;
      t_q         <= t_d;
      p_q         <= p_d;
      data_q      <= data_d;
      poly_q      <= poly_d;
      inj_en_q    <= inj_en_d;
      inj_pos_q   <= inj_pos_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      poly_err_q  <= poly_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Dout      = dout_q;
  assign poly_err  = poly_err_q;

endmodule

// File: tb/tb_edac_encode_4bit_seq.sv
// Bench for edac_encode_4bit_seq: fixed vector table, hand-written reset/backpressure
// sequences and randomized transactions checked against a behavioural model.
module tb_edac_encode_4bit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [3:0]  CRC_POLY;
  logic        inj_en;
  logic [3:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Dout;
  logic        poly_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  edac_encode_4bit_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .CRC_POLY(CRC_POLY), .inj_en(inj_en), .inj_pos(inj_pos),
    .out_valid(out_valid), .out_ready(out_ready), .Dout(Dout),
    .poly_err(poly_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    logic [3:0]  poly;
    logic        ie;
    logic [3:0]  ip;
    int          rdly;
    logic [15:0] exp_dout;
    logic        exp_perr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: remainder of d*x^4 by the polynomial, via plain mod-2 long division.
  function automatic logic [3:0] ref_crc(input logic [3:0] d, input logic [3:0] poly);
    int rem;
    rem = int'(d) << 4;
    for (int b = 7; b >= 4; b--) begin
      if (((rem >> b) & 1) == 1) rem = rem ^ (int'(poly) << (b - 3));
    end
    return 4'(rem);
  endfunction

  function automatic logic [15:0] ref_code(input logic [3:0] d, input logic [3:0] poly,
                                           input logic ie, input logic [3:0] ip);
    logic [15:0] c;
    logic [3:0]  crc;
    crc = ref_crc(d, poly);
    c = 16'({d, 8'h00});
    c[2] = crc[0]; c[4] = crc[1]; c[5] = crc[2]; c[6] = crc[3];
    c[0] = ^(c & 16'h0554);
    c[1] = ^(c & 16'h0664);
    c[3] = ^(c & 16'h0870);
    c[7] = ^(c & 16'h0F00);
    if (ie && ip < 12) c = c ^ (16'h1 << ip);
    return c;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; CRC_POLY = '0;
    inj_en = 1'b0; inj_pos = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", Dout, 16'h0000);
    chk("rst_poly_err", poly_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_txn(input string name, input logic [3:0] d, input logic [3:0] poly,
                         input logic ie, input logic [3:0] ip, input int rdly,
                         input logic [15:0] exp_dout, input logic exp_perr);
    int cyc;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; CRC_POLY = poly; inj_en = ie; inj_pos = ip;
    out_ready = 1'b0;
    chk({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = ~d; CRC_POLY = ~poly; inj_en = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      chk({name, "_busy_wait"}, busy, 1);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, "_latency"}, cyc, 5);
    chk({name, "_dout"}, Dout, exp_dout);
    chk({name, "_poly_err"}, poly_err, exp_perr);
    chk({name, "_in_ready_out"}, in_ready, 0);
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_dout"}, Dout, exp_dout);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, out_valid, 0);
    chk({name, "_idle_ready"}, in_ready, 1);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk({name, "_no_repeat"}, seen, 0);
  endtask

  initial begin
    vec_t vecs[$];
    do_reset();

    vecs.push_back('{4'hA, 4'hB, 1'b0, 4'd0,  0, 16'h0A39, 1'b0});
    vecs.push_back('{4'hF, 4'hB, 1'b0, 4'd0,  0, 16'h0F70, 1'b0});
    vecs.push_back('{4'h0, 4'hB, 1'b0, 4'd0,  0, 16'h0000, 1'b0});
    vecs.push_back('{4'hA, 4'hB, 1'b1, 4'd5,  0, 16'h0A19, 1'b0});
    vecs.push_back('{4'hA, 4'hB, 1'b1, 4'd13, 0, 16'h0A39, 1'b0});
    vecs.push_back('{4'hA, 4'h3, 1'b0, 4'd0,  0, 16'h0A39, 1'b1});
    vecs.push_back('{4'hA, 4'hB, 1'b0, 4'd0,  2, 16'h0A39, 1'b0});
    vecs.push_back('{4'hF, 4'hB, 1'b1, 4'd11, 1, 16'h0770, 1'b0});
    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].d, vecs[i].poly, vecs[i].ie,
              vecs[i].ip, vecs[i].rdly, vecs[i].exp_dout, vecs[i].exp_perr);

    // Backpressure with in_valid held and data changing: first word must stay put.
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'hF; CRC_POLY = 4'hB; inj_en = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (5) begin
      @(negedge clk);
      in_data = in_data + 4'd3;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_data = 4'(i);
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_dout", Dout, 16'h0F70);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_valid_drop", out_valid, 0);
    begin
      int seen;
      seen = 0;
      repeat (10) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      chk("bp_single_handshake", seen, 0);
    end

    // Asynchronous reset during the second DIV cycle.
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'h5; CRC_POLY = 4'hB;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_dout", Dout, 16'h0000);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (10) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      chk("midrst_no_emit", seen, 0);
    end

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] d, poly, ip;
      logic       ie;
      int         rdly;
      d    = 4'($urandom);
      poly = 4'($urandom);
      ie   = 1'($urandom);
      ip   = 4'($urandom);
      rdly = $urandom_range(0, 2);
      run_txn($sformatf("rnd%0d", n), d, poly, ie, ip, rdly,
              ref_code(d, poly, ie, ip), ~poly[3]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/edac_encode_4bit_seq.md
Name: edac_encode_4bit_seq

Overview:
- Sequential EDAC encoder that sits directly upstream of the 4-bit EDAC decoder.
- Takes a 4-bit data nibble and a 4-bit CRC polynomial and computes the CRC nibble by bit-serial long division, one step per cycle.
- Wraps data+CRC in a Hamming(12,8) code and emits the 16-bit codeword exactly in the decoder's input layout.
- Optional single-bit fault injection lets benches exercise the decoder's correction path.

Parameters:
- DIV_STEPS, 4, number of long-division steps; fixed by the 4-bit polynomial, not to be overridden.
- INJ_EN_DEFAULT, 0, reserved; injection is controlled only by the port (keep 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low (already decided).
- in_valid  in  1  input word offered.
- in_ready  out  1  block can accept a word (high only in IDLE).
- in_data  in  4  data nibble d[3:0].
- CRC_POLY  in  4  CRC polynomial, same coding as the decoder's CRC_POLY.
- inj_en  in  1  flip one codeword bit on this transaction.
- inj_pos  in  4  codeword bit index to flip; 0..11 valid.
- out_valid  out  1  codeword available.
- out_ready  in  1  consumer accepts codeword.
- Dout  out  16  encoded codeword.
- poly_err  out  1  captured CRC_POLY[3]==0 (polynomial cannot be checked by the decoder); qualified by out_valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, Dout=16'h0000, poly_err=0, busy=0, step counter=0, all capture registers=0.
- Reset is asynchronous, including mid-operation: any in-flight word is discarded and never emitted.
- FSM states: IDLE -> DIV -> HAM -> OUT -> IDLE.
- IDLE: in_ready=1. On in_valid && in_ready:
  - capture in_data, CRC_POLY, inj_en, inj_pos;
  - load the division register t[7:0]={in_data,4'b0000} and the shifted polynomial p[7:0]={CRC_POLY,4'b0000};
  - clear step counter k; go to DIV.
- DIV: lasts exactly 4 cycles, k=0..3. Each cycle:
  - if t[7-k]==1 then t<=t^p;
  - p<=p>>1; k<=k+1.
  - After k==3, go to HAM.
  - Inputs are ignored throughout DIV; in_ready=0.
- CRC result: crc[3:0]=t[3:0] after the 4 steps. With CRC_POLY[3]==1, t[7:4] is then 0 and t[0] is 0.
- HAM (1 cycle): build the codeword c[15:0], register it into Dout, set out_valid, go to OUT.
  - Message bits: c[2]=crc0, c[4]=crc1, c[5]=crc2, c[6]=crc3, c[8]=d0, c[9]=d1, c[10]=d2, c[11]=d3.
  - c[15:12]=0.
  - Parity bits:
    - c[0]=c2^c4^c6^c8^c10
    - c[1]=c2^c5^c6^c9^c10
    - c[3]=c4^c5^c6^c11
    - c[7]=c8^c9^c10^c11
  - Fault injection: applied after parity generation. If inj_en && inj_pos<12, c[inj_pos] is inverted. inj_pos 12..15 causes no flip.
  - poly_err <= ~captured_poly[3].
- OUT: out_valid=1; Dout and poly_err held stable until out_ready.
  - On out_ready: out_valid<=0, go to IDLE.
  - There is no acceptance of a new input in the same cycle (in_ready is still 0 in OUT).
- Latency: if the acceptance edge is E, out_valid is high after edge E+5. Minimum initiation interval is 6 cycles (7 when out_ready arrives one cycle late; each extra OUT cycle adds one).
- Dout keeps its last value after the handshake; it is only meaningful while out_valid=1.
- Encoder/decoder contract: with CRC_POLY[3]==1 and no injection, the decoder's CRC check passes on Dout and returns in_data.

Test Plan:
- Reset mid-DIV: assert rst_n=0 during the 2nd DIV cycle -> out_valid=0, Dout=0, in_ready=1 immediately; no codeword is emitted after release.
- Basic: in_data=4'hA, CRC_POLY=4'hB, out_ready=1 -> Dout=16'h0A39, poly_err=0; out_valid is high exactly after edge E+5 and for 1 cycle.
- Second vector: in_data=4'hF, CRC_POLY=4'hB -> Dout=16'h0F70. in_data=4'h0 -> Dout=16'h0000.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and changing in_data -> Dout is stable at the first word, in_ready=0 throughout; exactly one handshake occurs after out_ready rises.
- Injection: in_data=4'hA, CRC_POLY=4'hB, inj_en=1:
  - inj_pos=5 -> Dout=16'h0A19;
  - inj_pos=13 -> Dout=16'h0A39.
  - Feeding each into the decoder returns data 4'hA with valid=1.
- Poly error: CRC_POLY=4'h3 -> poly_err=1 with out_valid; the codeword is still emitted with the FSM sequence unchanged.
